regfile_write_arbiter: RTL and testbench

//  Write-side front end of the 32x32 register file: sole driver of its write port and JAL link port.

---
 rtl/regfile_write_arbiter_pkg.sv | 20 ++
 rtl/regfile_write_arbiter_wb_hold_buffer.sv | 71 +++++++
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write side.
package regfile_write_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
  localparam int unsigned ZERO_REG   = 0;
  localparam int unsigned LINK_REG   = 31;
  localparam int unsigned STARVE_MAX = 4;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry hold buffer for long-latency results, with a starvation age
// counter that raises stall_req once the entry has waited STARVE_MAX cycles.
module regfile_write_arbiter_wb_hold_buffer #(
  parameter int unsigned DATA_W     = regfile_write_arbiter_pkg::WORD_W,
  parameter int unsigned ADDR_W     = regfile_write_arbiter_pkg::REG_ADDR_W,
  parameter int unsigned STARVE_MAX = regfile_write_arbiter_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              hold_valid,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0] hold_data,
  output logic              stall_req
);

  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              stall_req_q, stall_req_d;

  // Drain empties the entry; a same-cycle load refills it.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    age_d        = age_q;
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    if (load) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = load_addr;
      hold_data_d  = load_data;
    end
    if (!hold_valid_q || drain) begin
      age_d = '0;
    end else if (age_q < AGE_W'(STARVE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
    stall_req_d = hold_valid_d && (age_d >= AGE_W'(STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      age_q        <= '0;
      stall_req_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      age_q        <= age_d;
      stall_req_q  <= stall_req_d;
    end
  end

  assign hold_valid = hold_valid_q;
  assign hold_addr  = hold_addr_q;
  assign hold_data  = hold_data_q;
  assign stall_req  = stall_req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side front end of the register file: arbitrates ALU, buffered
// long-latency and JAL link writes onto one registered port; keeps busy scoreboard.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W     = regfile_write_arbiter_pkg::WORD_W,
  parameter int unsigned ADDR_W     = regfile_write_arbiter_pkg::REG_ADDR_W,
  parameter int unsigned LINK_REG   = regfile_write_arbiter_pkg::LINK_REG,
  parameter int unsigned STARVE_MAX = regfile_write_arbiter_pkg::STARVE_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      jal_valid,
  input  logic [DATA_W-1:0]         jal_pc4,
  input  logic                      issue_valid,
  input  logic                      issue_long,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic                      stall_req,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      jump_and_link,
  output logic [DATA_W-1:0]         pc_4
);

  import regfile_write_arbiter_pkg::*;

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              alu_eff;
  logic              drain;
  logic              ld_fire;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              jump_and_link_q, jump_and_link_d;
  logic [DATA_W-1:0] pc_4_q, pc_4_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  // JAL owns the link register: a colliding ALU or held write must yield.
  assign alu_eff  = alu_valid && !(jal_valid && (alu_addr == LINK_ADDR));
  assign drain    = hold_valid && !alu_eff && !(jal_valid && (hold_addr == LINK_ADDR));
  assign ld_ready = !hold_valid || drain;
  assign ld_fire  = ld_valid && ld_ready;

  regfile_write_arbiter_wb_hold_buffer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld_fire),
    .load_addr  (ld_addr),
    .load_data  (ld_data),
    .drain      (drain),
    .hold_valid (hold_valid),
    .hold_addr  (hold_addr),
    .hold_data  (hold_data),
    .stall_req  (stall_req)
  );

  // Write-port select; writes to reg 0 consume the slot without a strobe.
  always_comb begin
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    jump_and_link_d = jal_valid;
    pc_4_d          = jal_pc4;
    if (alu_eff) begin
      if (alu_addr != ZERO_ADDR) begin
        wr_en_d   = 1'b1;
        wr_addr_d = alu_addr;
        wr_data_d = alu_data;
      end
    end else if (drain) begin
      if (hold_addr != ZERO_ADDR) begin
        wr_en_d   = 1'b1;
        wr_addr_d = hold_addr;
        wr_data_d = hold_data;
      end
    end
  end

  // Scoreboard: a new long issue overrides a same-cycle clear of the same reg.
  always_comb begin
    busy_d = busy_q;
    if (drain) begin
      busy_d[hold_addr] = 1'b0;
    end
    if (issue_valid && issue_long && (issue_addr != ZERO_ADDR)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      jump_and_link_q <= 1'b0;
      pc_4_q          <= '0;
      busy_q          <= '0;
    end else begin
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      jump_and_link_q <= jump_and_link_d;
      pc_4_q          <= pc_4_d;
      busy_q          <= busy_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign jump_and_link = jump_and_link_q;
  assign pc_4          = pc_4_q;
  assign busy          = busy_q;

  // An ALU result targeting a pending long-latency register means decode missed a hazard.
  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_valid && (alu_addr != ZERO_ADDR) && busy_q[alu_addr]));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for single-cycle
// arbitration plus hand sequences for long-latency, starvation and reset.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        jal_valid;
  logic [31:0] jal_pc4;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_addr;
  logic [31:0] busy;
  logic        stall_req;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        jump_and_link;
  logic [31:0] pc_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .jal_valid     (jal_valid),
    .jal_pc4       (jal_pc4),
    .issue_valid   (issue_valid),
    .issue_long    (issue_long),
    .issue_addr    (issue_addr),
    .busy          (busy),
    .stall_req     (stall_req),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .jump_and_link (jump_and_link),
    .pc_4          (pc_4)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        jal_v;
    logic [31:0] jal_p;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_jal;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    jal_valid = 1'b0; jal_pc4 = '0;
    issue_valid = 1'b0; issue_long = 1'b0; issue_addr = '0;
  endtask

  task automatic chk_wr(input string nm, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({nm, ".wr_en"}, 32'(wr_en), 32'(en));
    chk({nm, ".wr_addr"}, 32'(wr_addr), 32'(a));
    chk({nm, ".wr_data"}, wr_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'h12345678, 1'b1, 32'h00400008, 1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 32'h00400008};
    vecs[4] = '{1'b1, 5'd7,  32'h00000077, 1'b1, 32'h00000100, 1'b1, 5'd7,  32'h00000077, 1'b1, 32'h00000100};
    vecs[5] = '{1'b1, 5'd31, 32'h000000AA, 1'b0, 32'h0,        1'b1, 5'd31, 32'h000000AA, 1'b0, 32'h0};

    // Reset values
    #7;
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.jal", 32'(jump_and_link), 32'h0);
    chk("reset.pc_4", pc_4, 32'h0);
    chk("reset.busy", busy, 32'h0);
    chk("reset.stall", 32'(stall_req), 32'h0);
    chk("reset.ld_ready", 32'(ld_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle arbitration table
    for (int i = 0; i < 6; i++) begin
      alu_valid = vecs[i].alu_v; alu_addr = vecs[i].alu_a; alu_data = vecs[i].alu_d;
      jal_valid = vecs[i].jal_v; jal_pc4 = vecs[i].jal_p;
      tick();
      chk_wr($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata);
      chk($sformatf("vec%0d.jal", i), 32'(jump_and_link), 32'(vecs[i].e_jal));
      chk($sformatf("vec%0d.pc_4", i), pc_4, vecs[i].e_pc4);
      chk($sformatf("vec%0d.busy", i), busy, 32'h0);
    end
    idle();
    tick();
    chk_wr("idle_hold", 1'b0, 5'd31, 32'h000000AA);

    // Long-latency load to reg 8: write lands two edges after handshake
    issue_valid = 1'b1; issue_long = 1'b1; issue_addr = 5'd8;
    tick();
    chk("ld8.busy_set", busy, 32'h00000100);
    idle();
    ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h1234;
    #1 chk("ld8.ready_empty", 32'(ld_ready), 32'h1);
    tick();
    chk_wr("ld8.loaded", 1'b0, 5'd31, 32'h000000AA);
    chk("ld8.busy_held", busy, 32'h00000100);
    idle();
    #1 chk("ld8.ready_drain", 32'(ld_ready), 32'h1);
    tick();
    chk_wr("ld8.drained", 1'b1, 5'd8, 32'h1234);
    chk("ld8.busy_clr", busy, 32'h0);

    // Set and clear of the same reg in one cycle: set wins
    issue_valid = 1'b1; issue_long = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
    tick();
    idle();
    issue_valid = 1'b1; issue_long = 1'b1; issue_addr = 5'd9;
    tick();
    chk_wr("setwin", 1'b1, 5'd9, 32'h99);
    chk("setwin.busy", busy, 32'h00000200);
    idle();

    // Long result to reg 0: slot consumed, no strobe
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h5;
    tick();
    idle();
    tick();
    chk_wr("ld0", 1'b0, 5'd9, 32'h99);
    chk("ld0.ready", 32'(ld_ready), 32'h1);
    chk("ld0.busy", busy, 32'h00000200);

    // Held link-reg result waits behind a JAL
    ld_valid = 1'b1; ld_addr = 5'd31; ld_data = 32'h31;
    tick();
    idle();
    jal_valid = 1'b1; jal_pc4 = 32'h44;
    #1 chk("link.ready_blocked", 32'(ld_ready), 32'h0);
    tick();
    chk_wr("link.jal", 1'b0, 5'd9, 32'h99);
    chk("link.jal_strobe", 32'(jump_and_link), 32'h1);
    chk("link.pc_4", pc_4, 32'h44);
    idle();
    tick();
    chk_wr("link.drain", 1'b1, 5'd31, 32'h31);
    chk("link.jal_off", 32'(jump_and_link), 32'h0);

    // Starvation: ALU every cycle, stall after four waits, bubble drains and refills
    ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h00C0FFEE;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h300;
    tick();
    chk_wr("starve.load", 1'b1, 5'd3, 32'h300);
    chk("starve.stall0", 32'(stall_req), 32'h0);
    ld_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      alu_data = 32'h300 + 32'(k);
      #1 chk($sformatf("starve.ready%0d", k), 32'(ld_ready), 32'h0);
      tick();
      chk($sformatf("starve.wdata%0d", k), wr_data, 32'h300 + 32'(k));
      chk($sformatf("starve.stall%0d", k), 32'(stall_req), (k >= 4) ? 32'h1 : 32'h0);
    end
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 5'd13; ld_data = 32'h00000D13;
    #1 chk("starve.ready_bubble", 32'(ld_ready), 32'h1);
    tick();
    chk_wr("starve.drain", 1'b1, 5'd12, 32'h00C0FFEE);
    chk("starve.stall_off", 32'(stall_req), 32'h0);
    idle();
    tick();
    chk_wr("starve.refill", 1'b1, 5'd13, 32'h00000D13);

    // Asynchronous reset with hold full and busy set
    issue_valid = 1'b1; issue_long = 1'b1; issue_addr = 5'd8;
    tick();
    idle();
    ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h88;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
    tick();
    chk("rst.busy_pre", busy, 32'h00000300);
    ld_valid = 1'b0; alu_data = 32'h23;
    #1 chk("rst.ready_full", 32'(ld_ready), 32'h0);
    #3 rst_n = 1'b0;
    #1;
    chk_wr("rst.async", 1'b0, 5'd0, 32'h0);
    chk("rst.busy", busy, 32'h0);
    chk("rst.stall", 32'(stall_req), 32'h0);
    chk("rst.jal", 32'(jump_and_link), 32'h0);
    chk("rst.pc_4", pc_4, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.ready_after", 32'(ld_ready), 32'h1);
    chk_wr("rst.no_drain", 1'b0, 5'd0, 32'h0);
    chk("rst.busy_after", busy, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
